// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue pairing issued branch predictions with resolved outcomes.
// Define BRQ_STATS_EN to enable saturating branch/mispredict counters (otherwise tied to 0).
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [PC_WIDTH-1:0]      pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     upd_valid,
  output logic [PC_WIDTH-1:0]      upd_pc,
  output logic                     upd_taken,
  output logic                     upd_mispredict,
  output logic                     res_error,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_WIDTH-1:0]     total_branches,
  output logic [CNT_WIDTH-1:0]     total_mispredicts
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [PC_WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [PC_WIDTH:0] head;
  logic empty, full, push, pop, mis;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign pred_ready = !full;
  assign push = pred_valid && !full && !flush;
  assign pop = res_valid && !empty;
  assign head = mem[rd_ptr];
  assign mis = head[0] ^ res_taken;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {pred_pc, pred_taken};
  // Flush still lets a same-cycle resolve drain the old head into the update record.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      upd_valid <= 1'b0;
      upd_pc <= '0;
      upd_taken <= 1'b0;
      upd_mispredict <= 1'b0;
      res_error <= 1'b0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      count <= flush ? '0 : count + CW'(push) - CW'(pop);
      upd_valid <= pop;
      upd_pc <= pop ? head[PC_WIDTH:1] : '0;
      upd_taken <= pop && res_taken;
      upd_mispredict <= pop && mis;
      res_error <= res_valid && empty;
    end
`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      total_branches <= '0;
      total_mispredicts <= '0;
    end else begin
      if (pop && total_branches != '1) total_branches <= total_branches + CNT_WIDTH'(1);
      if (pop && mis && total_mispredicts != '1) total_mispredicts <= total_mispredicts + CNT_WIDTH'(1);
    end
`else
  assign total_branches = '0;
  assign total_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int PW = 8;
  localparam int CNTW = 4;
  logic clk = 0;
  logic reset;
  logic pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0, flush = 0;
  logic [PW-1:0] pred_pc = 0;
  logic pred_ready, upd_valid, upd_taken, upd_mispredict, res_error;
  logic [PW-1:0] upd_pc;
  logic [$clog2(DEPTH):0] count;
  logic [CNTW-1:0] total_branches, total_mispredicts;
  int checks = 0, passed = 0;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .res_error(res_error), .count(count), .total_branches(total_branches),
    .total_mispredicts(total_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending predictions as a plain FIFO of {pc, predicted}.
  logic [PW:0] mq[$];
  int sz;
  bit e_uv, e_ut, e_um, e_err;
  int e_upc, e_tb, e_tm;
  localparam int SAT = (1 << CNTW) - 1;
  always @(posedge clk or posedge reset)
    if (reset) begin
      mq.delete();
      {e_uv, e_ut, e_um, e_err} = '0;
      e_upc = 0; e_tb = 0; e_tm = 0;
    end else begin
      sz = mq.size();
      e_err = res_valid && sz == 0;
      e_uv = res_valid && sz > 0;
      e_upc = 0; e_ut = 0; e_um = 0;
      if (e_uv) begin
        e_upc = int'(mq[0][PW:1]);
        e_ut = res_taken;
        e_um = mq[0][0] != res_taken;
        if (e_tb < SAT) e_tb++;
        if (e_um && e_tm < SAT) e_tm++;
        void'(mq.pop_front());
      end
      if (flush) mq.delete();
      else if (pred_valid && sz < DEPTH) mq.push_back({pred_pc, pred_taken});
    end

  always @(negedge clk) begin
    chk("count", count, mq.size());
    chk("pred_ready", pred_ready, mq.size() < DEPTH);
    chk("upd_valid", upd_valid, e_uv);
    chk("upd_pc", upd_pc, e_upc);
    chk("upd_taken", upd_taken, e_ut);
    chk("upd_mispredict", upd_mispredict, e_um);
    chk("res_error", res_error, e_err);
`ifdef BRQ_STATS_EN
    chk("total_branches", total_branches, e_tb);
    chk("total_mispredicts", total_mispredicts, e_tm);
`else
    chk("total_branches", total_branches, 0);
    chk("total_mispredicts", total_mispredicts, 0);
`endif
  end

  task automatic step(input bit pv, input int pc, input bit pt, input bit rv, input bit rt, input bit fl);
    pred_valid = pv; pred_pc = PW'(pc); pred_taken = pt;
    res_valid = rv; res_taken = rt; flush = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1;
    #1;
    chk("rst pred_ready", pred_ready, 1);
    chk("rst count", count, 0);
    chk("rst upd_valid", upd_valid, 0);
    @(negedge clk); #1;
    reset = 0;
    // Basic push/resolve with mispredict on the middle entry
    step(1, 10, 1, 0, 0, 0);
    step(1, 20, 0, 0, 0, 0);
    step(1, 30, 1, 0, 0, 0);
    chk("t1 count", count, 3);
    step(0, 0, 0, 1, 1, 0);
    chk("t1 pc0", upd_pc, 10); chk("t1 mis0", upd_mispredict, 0); chk("t1 v0", upd_valid, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("t1 pc1", upd_pc, 20); chk("t1 mis1", upd_mispredict, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("t1 pc2", upd_pc, 30); chk("t1 mis2", upd_mispredict, 0);
`ifdef BRQ_STATS_EN
    chk("t1 branches", total_branches, 3); chk("t1 mispredicts", total_mispredicts, 1);
`endif
    idle();
    chk("t1 pulse end", upd_valid, 0);
    // Fill to full, overflow push ignored, drain across pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1, 100 + i, i[0], 0, 0, 0);
    chk("t2 ready", pred_ready, 0);
    chk("t2 count", count, 8);
    step(1, 200, 1, 0, 0, 0);
    chk("t2 ovf count", count, 8);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("t2 drain pc", upd_pc, 100 + i);
    end
    chk("t2 empty", count, 0);
    // Resolve on empty queue
    step(0, 0, 0, 1, 1, 0);
    chk("t3 err", res_error, 1); chk("t3 upd", upd_valid, 0); chk("t3 count", count, 0);
    idle();
    chk("t3 err pulse", res_error, 0);
    // Simultaneous push and resolve
    step(1, 1, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    step(1, 5, 1, 1, 0, 0);
    chk("t4 count", count, 3); chk("t4 pc", upd_pc, 1);
    step(0, 0, 0, 1, 1, 0); chk("t4 d1", upd_pc, 2);
    step(0, 0, 0, 1, 1, 0); chk("t4 d2", upd_pc, 3);
    step(0, 0, 0, 1, 1, 0); chk("t4 d3", upd_pc, 5); chk("t4 d3 mis", upd_mispredict, 0);
    // Flush with concurrent resolve and dropped push
    for (int i = 0; i < 4; i++) step(1, 40 + i, 1, 0, 0, 0);
    step(1, 99, 1, 1, 0, 1);
    chk("t5 upd", upd_valid, 1); chk("t5 pc", upd_pc, 40); chk("t5 mis", upd_mispredict, 1);
    chk("t5 count", count, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5 dropped", res_error, 1);
    // Asynchronous reset between edges
    step(1, 7, 1, 0, 0, 0);
    step(1, 8, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("t6 pre upd", upd_valid, 1);
    #2 reset = 1;
    #1;
    chk("t6 count", count, 0); chk("t6 ready", pred_ready, 1);
    chk("t6 upd", upd_valid, 0); chk("t6 pc", upd_pc, 0);
    chk("t6 branches", total_branches, 0);
    idle();
    reset = 0;
    // Back-to-back push+resolve to saturate counters
    step(1, 50, 0, 0, 0, 0);
    for (int i = 0; i < SAT + 3; i++) begin
      step(1, 51 + i, 0, 1, 1, 0);
      chk("t7 count", count, 1);
      chk("t7 mis", upd_mispredict, 1);
    end
`ifdef BRQ_STATS_EN
    chk("t7 sat branches", total_branches, SAT);
    chk("t7 sat mispredicts", total_mispredicts, SAT);
`endif
    idle();
    idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
